mult_div_unit: RTL and testbench



---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mdu_sign_fix.sv | 51 +++++
 rtl/mult_div_unit.sv | 177 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - mdu_op_e    : operation encodings carried on the 2-bit op port
//   - mdu_state_e : FSM states of mult_div_unit
//   - MDU_ITERS   : number of RUN iterations (one per operand bit)
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } mdu_state_e;

    localparam int MDU_ITERS = 32;

endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: combinational sign correction applied in the FIX state.
// The iteration always works on magnitudes, so the raw result is unsigned.
// Multiplies negate the whole double-width product; divides negate the
// quotient and the remainder independently.
// Ports:
//   op      in  operation being completed (mdu_op_e encoding)
//   sign_q  in  product/quotient must be negated (signed ops only)
//   sign_r  in  remainder must be negated (signed divide only)
//   raw_hi  in  product high half / remainder magnitude
//   raw_lo  in  product low half / quotient magnitude
//   fix_hi  out corrected HI value
//   fix_lo  out corrected LO value
module mdu_sign_fix
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       op,
    input  logic             sign_q,
    input  logic             sign_r,
    input  logic [WIDTH-1:0] raw_hi,
    input  logic [WIDTH-1:0] raw_lo,
    output logic [WIDTH-1:0] fix_hi,
    output logic [WIDTH-1:0] fix_lo
);

    logic [2*WIDTH-1:0] prod_neg;
    logic               is_div;
    logic               is_signed;

    // The sign flags are only ever set for signed ops; gating them with the
    // signed bit keeps an unsigned op from being corrupted by stale flags.
    always_comb begin
        prod_neg  = -{raw_hi, raw_lo};
        is_div    = (op == MDU_DIVU) || (op == MDU_DIV);
        is_signed = (op == MDU_MULT) || (op == MDU_DIV);
        fix_hi    = raw_hi;
        fix_lo    = raw_lo;
        if (is_div) begin
            if (is_signed && sign_q) begin
                fix_lo = -raw_lo;
            end
            if (is_signed && sign_r) begin
                fix_hi = -raw_hi;
            end
        end else if (is_signed && sign_q) begin
            {fix_hi, fix_lo} = prod_neg;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit owning the HI/LO registers.
// Executes MULTU/MULT (radix-2 shift-add) and DIVU/DIV (restoring division),
// one operand bit per RUN cycle, followed by a single FIX cycle that applies
// sign correction and writes HI/LO. Result visible 34 clocks after start.
// Optional feature macro: MDU_HILO_WRITE_EN adds MTHI/MTLO write ports.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start, op      request and operation (sampled only while idle)
//   a, b           multiplicand/dividend, multiplier/divisor
//   busy, done     operation in progress, one-cycle completion pulse
//   hi, lo         architectural HI/LO registers
//   hi_we, lo_we   (MDU_HILO_WRITE_EN) MTHI/MTLO enables, honoured in IDLE
//   wdata          (MDU_HILO_WRITE_EN) MTHI/MTLO data
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MDU_HILO_WRITE_EN
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_e       state_q, state_d;
    logic [CW-1:0]    count_q;
    logic [1:0]       op_q;
    logic             sign_q_q, sign_r_q, div_zero_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH:0]   acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic [WIDTH-1:0] a_orig_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q;

    logic             op_signed, op_div;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             div_ge;
    logic [WIDTH:0]   acc_hi_d;
    logic [WIDTH-1:0] acc_lo_d;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Operand magnitudes for the start capture; unsigned ops pass through.
    always_comb begin
        op_signed = (op == MDU_MULT) || (op == MDU_DIV);
        op_div    = (op == MDU_DIVU) || (op == MDU_DIV);
        mag_a     = (op_signed && a[WIDTH-1]) ? -a : a;
        mag_b     = (op_signed && b[WIDTH-1]) ? -b : b;
    end

    // One iteration step. Multiply keeps the multiplier in acc_lo and shifts
    // product bits in from the top; divide shifts dividend bits out of acc_lo
    // into the partial remainder and shifts quotient bits in at the bottom.
    always_comb begin
        mul_sum   = acc_hi_q + {1'b0, (acc_lo_q[0] ? mcand_q : '0)};
        div_shift = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, mcand_q};
        div_ge    = ~div_diff[WIDTH+1];
        if ((op_q == MDU_DIVU) || (op_q == MDU_DIV)) begin
            acc_hi_d = div_ge ? div_diff[WIDTH:0] : div_shift;
            acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
            acc_hi_d = {1'b0, mul_sum[WIDTH:1]};
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .op     (op_q),
        .sign_q (sign_q_q),
        .sign_r (sign_r_q),
        .raw_hi (acc_hi_q[WIDTH-1:0]),
        .raw_lo (acc_lo_q),
        .fix_hi (fix_hi),
        .fix_lo (fix_lo)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: RUN lasts until the counter has stepped through 0.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (count_q == '0) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Iteration datapath: capture on start, step once per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            op_q       <= '0;
            sign_q_q   <= 1'b0;
            sign_r_q   <= 1'b0;
            div_zero_q <= 1'b0;
            mcand_q    <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            a_orig_q   <= '0;
        end else if (state_q == IDLE) begin
            if (start) begin
                count_q    <= CW'(WIDTH - 1);
                op_q       <= op;
                sign_q_q   <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                sign_r_q   <= op_signed & a[WIDTH-1];
                div_zero_q <= op_div & (b == '0);
                mcand_q    <= op_div ? mag_b : mag_a;
                acc_hi_q   <= '0;
                acc_lo_q   <= op_div ? mag_a : mag_b;
                a_orig_q   <= a;
            end
        end else if (state_q == RUN) begin
            count_q  <= count_q - CW'(1);
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
        end
    end

    // Architectural HI/LO. Divide by zero bypasses sign correction and
    // reports all-ones quotient with the untouched dividend as remainder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state_q == FIX) begin
            hi_q <= div_zero_q ? a_orig_q : fix_hi;
            lo_q <= div_zero_q ? '1 : fix_lo;
        end
`ifdef MDU_HILO_WRITE_EN
        else if (state_q == IDLE) begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
        end
`endif
    end

    // Completion pulse follows the single FIX cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == FIX);
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: self-checking bench for mult_div_unit.
// A cycle-level reference model (plain arithmetic plus a countdown of the
// 34-clock latency) is compared with the DUT on every falling edge; directed
// tests also pin hand-computed results. Build with +define+MDU_HILO_WRITE_EN
// to include the MTHI/MTLO tests.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;
`ifdef MDU_HILO_WRITE_EN
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
`ifdef MDU_HILO_WRITE_EN
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
`endif
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Architectural result of one operation, returned as {hi, lo}.
    function automatic logic [63:0] modelOp(input logic [1:0] mop, input logic [31:0] ma,
                                            input logic [31:0] mb);
        logic signed [31:0] sa, sb;
        logic signed [63:0] sp;
        logic [31:0] q, r;
        sa = ma;
        sb = mb;
        case (mop)
            MDU_MULTU: return {32'h0, ma} * {32'h0, mb};
            MDU_MULT: begin
                sp = sa * sb;
                return sp;
            end
            default: begin
                if (mb == 32'h0) return {ma, 32'hFFFF_FFFF};
                if (mop == MDU_DIVU) begin
                    q = ma / mb;
                    r = ma % mb;
                end else if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
                    q = 32'h8000_0000;
                    r = 32'h0;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                end
                return {r, q};
            end
        endcase
    endfunction

    // Reference model: mLeft counts the busy cycles still to come.
    int          mLeft = 0;
    logic        mDone = 1'b0;
    logic [31:0] mHi = '0, mLo = '0;
    logic [63:0] mPend = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mLeft <= 0;
            mDone <= 1'b0;
            mHi   <= '0;
            mLo   <= '0;
        end else begin
            mDone <= 1'b0;
            if (mLeft == 0) begin
`ifdef MDU_HILO_WRITE_EN
                if (hi_we) mHi <= wdata;
                if (lo_we) mLo <= wdata;
`endif
                if (start) begin
                    mPend <= modelOp(op, a, b);
                    mLeft <= 33;
                end
            end else begin
                mLeft <= mLeft - 1;
                if (mLeft == 1) begin
                    mHi   <= mPend[63:32];
                    mLo   <= mPend[31:0];
                    mDone <= 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        checkOutput("busy", {31'h0, busy}, {31'h0, (mLeft != 0)});
        checkOutput("done", {31'h0, done}, {31'h0, mDone});
        checkOutput("hi", hi, mHi);
        checkOutput("lo", lo, mLo);
    end

    // Pulse start for one cycle, then wait (bounded) for done.
    // lat counts clock edges from the start edge to the done-visible edge.
    task automatic applyStimulus(input logic [1:0] sop, input logic [31:0] sa,
                                 input logic [31:0] sb, output int lat);
        op    = sop;
        a     = sa;
        b     = sb;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1;
        while (lat < 60) begin
            @(posedge clk);
            #1 lat++;
            if (done) break;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout: done not seen, got %0d edges expected 34", lat);
        end
    endtask

    // Count done pulses over a number of cycles.
    task automatic countDone(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1 if (done) n++;
        end
    endtask

    int lat, n;
    logic [31:0] holdHi, holdLo;

    initial begin
        #10000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", {31'h0, busy}, 32'h0);
        checkOutput("reset_hi", hi, 32'h0);
        checkOutput("reset_lo", lo, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Model sanity pins.
        checkOutput("model_mult_lo", modelOp(MDU_MULT, 32'hFFFF_FFFD, 32'd7), 32'hFFFF_FFEB);
        checkOutput("model_div_hi", modelOp(MDU_DIV, 32'hFFFF_FFF9, 32'd2) >> 32, 32'hFFFF_FFFF);

        $display("[TB] MULTU latency and result");
        applyStimulus(MDU_MULTU, 32'hFFFF_FFFF, 32'h2, lat);
        checkOutput("latency", lat, 32'd34);
        checkOutput("multu_done", {31'h0, done}, 32'h1);
        checkOutput("multu_hi", hi, 32'h1);
        checkOutput("multu_lo", lo, 32'hFFFF_FFFE);

        // Issued in the done cycle: back-to-back acceptance.
        applyStimulus(MDU_MULT, 32'hFFFF_FFFD, 32'd7, lat);
        checkOutput("b2b_latency", lat, 32'd34);
        checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
        checkOutput("mult_lo", lo, 32'hFFFF_FFEB);

        applyStimulus(MDU_DIV, 32'hFFFF_FFF9, 32'd2, lat);
        checkOutput("div_lo", lo, 32'hFFFF_FFFD);
        checkOutput("div_hi", hi, 32'hFFFF_FFFF);

        applyStimulus(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        checkOutput("div_ovf_lo", lo, 32'h8000_0000);
        checkOutput("div_ovf_hi", hi, 32'h0);

        applyStimulus(MDU_DIV, 32'd7, 32'hFFFF_FFFE, lat);
        checkOutput("div_negb_lo", lo, 32'hFFFF_FFFD);
        checkOutput("div_negb_hi", hi, 32'h1);

        applyStimulus(MDU_DIVU, 32'd100, 32'd7, lat);
        checkOutput("divu_lo", lo, 32'd14);
        checkOutput("divu_hi", hi, 32'd2);

        applyStimulus(MDU_MULTU, 32'h0001_0000, 32'h0001_0000, lat);
        checkOutput("multu_carry_hi", hi, 32'h1);
        checkOutput("multu_carry_lo", lo, 32'h0);

        applyStimulus(MDU_MULT, 32'h8000_0000, 32'h8000_0000, lat);
        checkOutput("mult_minmin_hi", hi, 32'h4000_0000);
        checkOutput("mult_minmin_lo", lo, 32'h0);

        $display("[TB] DIVU by zero with ignored start");
        @(posedge clk);
        #1;
        op = MDU_DIVU; a = 32'd100; b = 32'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        op = MDU_MULTU; a = 32'd5; b = 32'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1 lat++;
        end
        checkOutput("div0_done_seen", {31'h0, done}, 32'h1);
        checkOutput("div0_lo", lo, 32'hFFFF_FFFF);
        checkOutput("div0_hi", hi, 32'd100);
        countDone(40, n);
        checkOutput("ignored_start_done", n, 32'd0);
        checkOutput("ignored_start_hi", hi, 32'd100);
        checkOutput("ignored_start_lo", lo, 32'hFFFF_FFFF);

        $display("[TB] reset during MULTU");
        op = MDU_MULTU; a = 32'd9; b = 32'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_busy", {31'h0, busy}, 32'h0);
        checkOutput("abort_done", {31'h0, done}, 32'h0);
        checkOutput("abort_hi", hi, 32'h0);
        checkOutput("abort_lo", lo, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        countDone(40, n);
        checkOutput("abort_no_done", n, 32'd0);
        applyStimulus(MDU_MULTU, 32'd3, 32'd4, lat);
        checkOutput("after_abort_lo", lo, 32'd12);
        checkOutput("after_abort_hi", hi, 32'd0);

`ifdef MDU_HILO_WRITE_EN
        $display("[TB] MTHI/MTLO writes");
        @(posedge clk);
        #1;
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 hi_we = 1'b0;
        checkOutput("mthi_hi", hi, 32'hDEAD_BEEF);
        checkOutput("mthi_lo", lo, 32'd12);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
        @(posedge clk);
        #1 begin hi_we = 1'b0; lo_we = 1'b0; end
        checkOutput("mthilo_hi", hi, 32'h1234_5678);
        checkOutput("mthilo_lo", lo, 32'h1234_5678);
        op = MDU_MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        holdHi = hi;
        hi_we = 1'b1; wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1 hi_we = 1'b0;
        checkOutput("busy_write_hi", hi, 32'h1234_5678);
        lat = 0;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1 lat++;
        end
        checkOutput("busy_write_done", {31'h0, done}, 32'h1);
        checkOutput("busy_write_lo", lo, 32'd42);
        checkOutput("busy_write_final_hi", hi, 32'd0);
        holdLo = holdHi;
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
